// File: rtl/farrow_ctrl.sv
// Farrow resampler control: phase accumulator, filter feed and keep-tag FIFO.
// Optional statistics counters are enabled with `define FARROW_CTRL_STATS_EN.
module farrow_ctrl #(
   parameter int TAG_DEPTH = 8,
   parameter int FLUSH_LEN = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic [15:0]        step_in,
   input  logic               in_valid,
   input  logic signed [15:0] in_data,
   output logic               in_ready,
   output logic               farrow_en,
   output logic signed [15:0] farrow_data,
   output logic signed [15:0] farrow_mu,
   input  logic               filt_valid,
   input  logic signed [15:0] filt_data,
   output logic               out_valid,
   output logic signed [15:0] out_data,
   output logic               busy,
   output logic               err
`ifdef FARROW_CTRL_STATS_EN
   ,
   output logic [31:0]        kept_cnt,
   output logic [31:0]        drop_cnt
`endif
);

   localparam int AW = $clog2(TAG_DEPTH);
   localparam int CW = AW + 1;
   localparam int FW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
   localparam logic [CW:0]   DEPTH_C = (CW+1)'(TAG_DEPTH);
   localparam logic [FW-1:0] FLAST   = FW'(FLUSH_LEN - 1);
   localparam logic [16:0]   ONE     = 17'd16384;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

   state_t        state_q, state_d;
   logic [15:0]   step_q;
   logic [16:0]   d_q;
   logic [FW-1:0] flush_cnt;
   logic          keep_r;

   logic [TAG_DEPTH-1:0] mem;
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [CW-1:0]        count;

   logic room, accept, inject, keep_now, pop, full, do_push, head;

   // Count the tag already sitting in the farrow register so its push can never overflow.
   assign room     = ({1'b0, count} + {{CW{1'b0}}, farrow_en}) < DEPTH_C;
   assign in_ready = (state_q == S_RUN) && room;
   assign accept   = in_valid && in_ready;
   assign inject   = (state_q == S_FLUSH) && room;
   assign keep_now = (d_q < ONE);
   assign full     = (count == DEPTH_C[CW-1:0]);
   assign pop      = filt_valid && (count != '0);
   assign do_push  = farrow_en && (!full || pop);
   assign head     = mem[rd_ptr];
   assign busy     = (state_q != S_IDLE) || (count != '0) || farrow_en;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (stop) state_d = S_FLUSH;
         S_FLUSH: if (inject && flush_cnt == FLAST) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         step_q      <= '0;
         d_q         <= '0;
         flush_cnt   <= '0;
         keep_r      <= 1'b0;
         farrow_en   <= 1'b0;
         farrow_data <= '0;
         farrow_mu   <= '0;
      end else begin
         state_q   <= state_d;
         farrow_en <= accept || inject;
         if (state_q == S_IDLE && start) begin
            step_q    <= (step_in < 16'd16384) ? 16'd16384 : step_in;
            d_q       <= '0;
            flush_cnt <= '0;
         end
         if (accept) begin
            farrow_data <= in_data;
            keep_r      <= keep_now;
            farrow_mu   <= keep_now ? {2'b00, d_q[13:0]} : 16'sd0;
            d_q         <= keep_now ? d_q + {1'b0, step_q} - ONE : d_q - ONE;
         end else if (inject) begin
            farrow_data <= '0;
            farrow_mu   <= '0;
            keep_r      <= 1'b0;
            flush_cnt   <= flush_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= keep_r;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         err       <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         if ((farrow_en && full && !pop) || (filt_valid && count == '0)) err <= 1'b1;
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         out_valid <= pop && head;
         if (pop && head) out_data <= filt_data;
      end
   end

`ifdef FARROW_CTRL_STATS_EN
   always_ff @(posedge clk) begin
      if (rst || (state_q == S_IDLE && start)) begin
         kept_cnt <= '0;
         drop_cnt <= '0;
      end else if (pop) begin
         if (head) kept_cnt <= kept_cnt + 32'd1;
         else      drop_cnt <= drop_cnt + 32'd1;
      end
   end
`endif

endmodule
